// File: rtl/overture_seq_pkg.sv
// Shared types and constants for the OVERTURE fetch/execute sequencer.
package overture_seq_pkg;

  typedef enum logic [1:0] {
    OP_IMM  = 2'b00,
    OP_CALC = 2'b01,
    OP_COPY = 2'b10,
    OP_COND = 2'b11
  } opcode_e;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } state_e;

  localparam logic [2:0] LOC_IO  = 3'd6;
  localparam logic [2:0] LOC_BAD = 3'd7;

  // Decoded view of the instruction register
  typedef struct packed {
    opcode_e    op;
    logic [2:0] src;
    logic [2:0] dst;
    logic [2:0] cond;
    logic       is_io_src;
    logic       is_io_dst;
    logic       illegal;
  } decode_t;

endpackage

// File: rtl/overture_seq_ctrl_if.sv
// Bus bundle between the OVERTURE sequencer and its program memory, datapath and I/O port.
interface overture_seq_ctrl_if #(
  parameter int unsigned PC_W = 8
);
  logic            imem_req;
  logic [PC_W-1:0] pc;
  logic            imem_valid;
  logic [7:0]      instr;
  logic [2:0]      rd_sel;
  logic [2:0]      wr_sel;
  logic            wr_en;
  logic            imm_en;
  logic            alu_en;
  logic [2:0]      cond_sel;
  logic            cond_true;
  logic [PC_W-1:0] jump_target;
  logic            in_valid;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic            retire;
  logic            err_illegal;
  logic            err_timeout;

  modport master (
    output imem_req, pc, rd_sel, wr_sel, wr_en, imm_en, alu_en, cond_sel,
           in_ready, out_valid, retire, err_illegal, err_timeout,
    input  imem_valid, instr, cond_true, jump_target, in_valid, out_ready
  );

  modport slave (
    input  imem_req, pc, rd_sel, wr_sel, wr_en, imm_en, alu_en, cond_sel,
           in_ready, out_valid, retire, err_illegal, err_timeout,
    output imem_valid, instr, cond_true, jump_target, in_valid, out_ready
  );
endinterface

// File: rtl/overture_seq_decode.sv
// Combinational instruction decode: opcode, copy locations, condition code and I/O / illegal flags.
module overture_seq_decode
  import overture_seq_pkg::*;
(
  input  logic [7:0] ir,
  output decode_t    dec
);

  always_comb begin
    dec           = '0;
    dec.op        = opcode_e'(ir[7:6]);
    dec.src       = ir[5:3];
    dec.dst       = ir[2:0];
    dec.cond      = ir[2:0];
    dec.is_io_src = (ir[5:3] == LOC_IO);
    dec.is_io_dst = (ir[2:0] == LOC_IO);
    // Location 7 only matters for COPY; other opcodes reuse the bits
    dec.illegal   = (opcode_e'(ir[7:6]) == OP_COPY) &&
                    ((ir[5:3] == LOC_BAD) || (ir[2:0] == LOC_BAD));
  end

endmodule

// File: rtl/overture_seq_ctrl.sv
// OVERTURE fetch/execute sequencer: owns the PC, fetches, decodes and stalls on I/O handshakes.
// Optional stall watchdog compiled in with OVERTURE_SEQ_WATCHDOG_EN.
module overture_seq_ctrl
  import overture_seq_pkg::*;
#(
  parameter int unsigned PC_W = 8
`ifdef OVERTURE_SEQ_WATCHDOG_EN
  , parameter int unsigned WDOG_MAX = 255
`endif
) (
  input  logic                clk,
  input  logic                rst,
  overture_seq_ctrl_if.master bus
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc;
  logic [7:0]      ir_q, ir_d;
  logic            err_illegal_q, err_illegal_d;
  decode_t         dec;

  logic            imem_req_c, wr_en_c, imm_en_c, alu_en_c;
  logic            in_ready_c, out_valid_c, retire_c;
  logic [2:0]      rd_sel_c, wr_sel_c, cond_sel_c;
  logic            fire_c, timeout_c, done_c, take_jump_c;

  overture_seq_decode u_decode (
    .ir  (ir_q),
    .dec (dec)
  );

  assign pc_inc = pc_q + PC_W'(1);

  // A COPY fires once every I/O side it touches is ready in the same cycle
  assign fire_c = !dec.illegal &&
                  (!dec.is_io_src || bus.in_valid) &&
                  (!dec.is_io_dst || bus.out_ready);

`ifdef OVERTURE_SEQ_WATCHDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_MAX + 1);

  logic [WDOG_W-1:0] wdog_q;
  logic              err_timeout_q;
  logic              stall_c;

  assign stall_c = !rst &&
                   (((state_q == S_FETCH) && !bus.imem_valid) ||
                    ((state_q == S_EXEC) && (dec.op == OP_COPY) && !dec.illegal && !fire_c));

  // Fires on the stall cycle that brings the count to WDOG_MAX
  assign timeout_c = stall_c && (wdog_q == WDOG_W'(WDOG_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q        <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      if (stall_c && !timeout_c) begin
        wdog_q <= wdog_q + WDOG_W'(1);
      end else begin
        wdog_q <= '0;
      end
      if (timeout_c) begin
        err_timeout_q <= 1'b1;
      end
    end
  end

  assign bus.err_timeout = err_timeout_q;
`else
  assign timeout_c       = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

  // Next-state, PC update and datapath strobes
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    err_illegal_d = err_illegal_q;
    imem_req_c    = 1'b0;
    wr_en_c       = 1'b0;
    imm_en_c      = 1'b0;
    alu_en_c      = 1'b0;
    in_ready_c    = 1'b0;
    out_valid_c   = 1'b0;
    retire_c      = 1'b0;
    rd_sel_c      = 3'd0;
    wr_sel_c      = 3'd0;
    cond_sel_c    = 3'd0;
    done_c        = 1'b0;
    take_jump_c   = 1'b0;

    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          imem_req_c = 1'b1;
          if (bus.imem_valid) begin
            ir_d    = bus.instr;
            state_d = S_EXEC;
          end else if (timeout_c) begin
            pc_d = pc_inc;
          end
        end

        S_EXEC: begin
          case (dec.op)
            OP_IMM: begin
              imm_en_c = 1'b1;
              done_c   = 1'b1;
            end
            OP_CALC: begin
              alu_en_c   = 1'b1;
              cond_sel_c = dec.cond;
              done_c     = 1'b1;
            end
            OP_COND: begin
              cond_sel_c  = dec.cond;
              take_jump_c = bus.cond_true;
              done_c      = 1'b1;
            end
            OP_COPY: begin
              rd_sel_c = dec.src;
              wr_sel_c = dec.dst;
              if (dec.illegal) begin
                // Retired as a NOP with no strobes or handshakes
                err_illegal_d = 1'b1;
                done_c        = 1'b1;
              end else begin
                out_valid_c = dec.is_io_dst;
                if (fire_c) begin
                  in_ready_c = dec.is_io_src;
                  wr_en_c    = !dec.is_io_dst;
                  done_c     = 1'b1;
                end else if (timeout_c) begin
                  done_c = 1'b1;
                end
              end
            end
            default: ;
          endcase

          if (done_c) begin
            retire_c = 1'b1;
            pc_d     = take_jump_c ? bus.jump_target : pc_inc;
            state_d  = S_FETCH;
          end
        end

        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      pc_q          <= '0;
      ir_q          <= '0;
      err_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      err_illegal_q <= err_illegal_d;
    end
  end

  assign bus.imem_req    = imem_req_c;
  assign bus.pc          = pc_q;
  assign bus.rd_sel      = rd_sel_c;
  assign bus.wr_sel      = wr_sel_c;
  assign bus.wr_en       = wr_en_c;
  assign bus.imm_en      = imm_en_c;
  assign bus.alu_en      = alu_en_c;
  assign bus.cond_sel    = cond_sel_c;
  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.retire      = retire_c;
  assign bus.err_illegal = err_illegal_q;

endmodule

// File: tb/tb_overture_seq_ctrl.sv
// Self-checking bench for overture_seq_ctrl: directed scenarios plus a randomized program
// checked against a transaction-level model; watchdog scenario runs when OVERTURE_SEQ_WATCHDOG_EN is set.
module tb_overture_seq_ctrl;

  localparam int unsigned PC_W = 8;
`ifdef OVERTURE_SEQ_WATCHDOG_EN
  localparam int unsigned WDOG_MAX = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  overture_seq_ctrl_if #(.PC_W(PC_W)) bus ();

  overture_seq_ctrl #(
    .PC_W(PC_W)
`ifdef OVERTURE_SEQ_WATCHDOG_EN
    , .WDOG_MAX(WDOG_MAX)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         fetch_cyc;
    int         exec_cyc;
    int         imm_n;
    int         alu_n;
    int         wr_n;
    int         wr_at;
    int         in_rdy_n;
    int         out_v_n;
    int         retire_n;
    bit         fetch_strobe;
    bit         sel_changed;
    logic [2:0] rd_sel;
    logic [2:0] wr_sel;
    logic [2:0] cond_sel;
    logic [7:0] pc_after;
  } obs_t;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_pc   = 8'h00;
  bit         exp_err  = 1'b0;

  // Expected behaviour of one instruction, from the opcode rules and handshake delays
  function automatic obs_t model(input logic [7:0] ins, input int fw, input int idl, input int odl,
                                 input bit ct, input logic [7:0] tgt, input logic [7:0] pc0);
    obs_t e;
    int   src, dst, f;
    e           = '{default: 0};
    e.wr_at     = -1;
    e.fetch_cyc = fw + 1;
    e.exec_cyc  = 1;
    e.retire_n  = 1;
    e.pc_after  = pc0 + 8'd1;
    src         = int'(ins[5:3]);
    dst         = int'(ins[2:0]);
    case (ins[7:6])
      2'b00: e.imm_n = 1;
      2'b01: begin e.alu_n = 1; e.cond_sel = ins[2:0]; end
      2'b11: begin e.cond_sel = ins[2:0]; if (ct) e.pc_after = tgt; end
      default: begin
        e.rd_sel = ins[5:3];
        e.wr_sel = ins[2:0];
        if (src != 7 && dst != 7) begin
          f = 0;
          if (src == 6 && idl > f) f = idl;
          if (dst == 6 && odl > f) f = odl;
          e.exec_cyc = f + 1;
          if (dst != 6) begin e.wr_n = 1; e.wr_at = f; end
          if (src == 6) e.in_rdy_n = 1;
          if (dst == 6) e.out_v_n = f + 1;
        end
      end
    endcase
    return e;
  endfunction

  // Drives one fetch + execute and records what the DUT did; starts and ends #1 after a posedge in FETCH
  task automatic run_instr(input logic [7:0] ins, input int fw, input int idl, input int odl,
                           input bit ct, input logic [7:0] tgt, output obs_t o);
    bit got;
    got     = 1'b0;
    o       = '{default: 0};
    o.wr_at = -1;
    for (int w = 0; w <= fw; w++) begin
      bus.imem_valid = (w == fw);
      bus.instr      = (w == fw) ? ins : 8'($urandom_range(0, 255));
      @(negedge clk);
      if (bus.imem_req === 1'b1) o.fetch_cyc++;
      if ((bus.wr_en | bus.imm_en | bus.alu_en | bus.in_ready | bus.out_valid | bus.retire) !== 1'b0)
        o.fetch_strobe = 1'b1;
      @(posedge clk); #1;
    end
    bus.imem_valid = 1'b0;
    for (int k = 0; k < 64 && !got; k++) begin
      bus.in_valid    = (k >= idl);
      bus.out_ready   = (k >= odl);
      bus.cond_true   = ct;
      bus.jump_target = tgt;
      @(negedge clk);
      o.exec_cyc++;
      if (bus.imm_en === 1'b1) o.imm_n++;
      if (bus.alu_en === 1'b1) o.alu_n++;
      if (bus.in_ready === 1'b1) o.in_rdy_n++;
      if (bus.out_valid === 1'b1) o.out_v_n++;
      if (bus.wr_en === 1'b1) begin o.wr_n++; o.wr_at = k; end
      if (k == 0) begin
        o.rd_sel = bus.rd_sel; o.wr_sel = bus.wr_sel; o.cond_sel = bus.cond_sel;
      end else if (bus.rd_sel !== o.rd_sel || bus.wr_sel !== o.wr_sel || bus.cond_sel !== o.cond_sel) begin
        o.sel_changed = 1'b1;
      end
      if (bus.retire === 1'b1) begin o.retire_n++; got = 1'b1; end
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.cond_true = 1'b0;
    o.pc_after    = bus.pc;
  endtask

  task automatic test_reset();
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.pc !== 8'h00) $display("FAIL reset_pc: got %h want 00", bus.pc); else n_pass++;
    n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL reset_imem_req: got %b want 0", bus.imem_req); else n_pass++;
    n_checks++; if (bus.retire !== 1'b0) $display("FAIL reset_retire: got %b want 0", bus.retire); else n_pass++;
    n_checks++; if (bus.err_illegal !== 1'b0) $display("FAIL reset_err_illegal: got %b want 0", bus.err_illegal); else n_pass++;
    n_checks++; if (bus.err_timeout !== 1'b0) $display("FAIL reset_err_timeout: got %b want 0", bus.err_timeout); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.imem_req !== 1'b1) $display("FAIL post_reset_fetch: got %b want 1", bus.imem_req); else n_pass++;
    @(posedge clk); #1;
    exp_pc = 8'h00;
  endtask

  task automatic test_imm();
    obs_t o;
    run_instr(8'h05, 0, 0, 0, 1'b0, 8'h00, o);
    n_checks++; if (o.fetch_cyc !== 1) $display("FAIL imm_fetch_cycles: got %0d want 1", o.fetch_cyc); else n_pass++;
    n_checks++; if (o.exec_cyc !== 1) $display("FAIL imm_exec_cycles: got %0d want 1", o.exec_cyc); else n_pass++;
    n_checks++; if (o.imm_n !== 1) $display("FAIL imm_en_count: got %0d want 1", o.imm_n); else n_pass++;
    n_checks++; if (o.fetch_strobe !== 1'b0) $display("FAIL imm_strobe_in_fetch: got %b want 0", o.fetch_strobe); else n_pass++;
    n_checks++; if (o.pc_after !== exp_pc + 8'd1) $display("FAIL imm_pc: got %h want %h", o.pc_after, exp_pc + 8'd1); else n_pass++;
    exp_pc = exp_pc + 8'd1;
  endtask

  task automatic test_calc();
    obs_t o;
    run_instr(8'h45, 0, 0, 0, 1'b0, 8'h00, o);
    n_checks++; if (o.alu_n !== 1) $display("FAIL calc_alu_en: got %0d want 1", o.alu_n); else n_pass++;
    n_checks++; if (o.cond_sel !== 3'd5) $display("FAIL calc_cond_sel: got %0d want 5", o.cond_sel); else n_pass++;
    n_checks++; if (o.pc_after !== exp_pc + 8'd1) $display("FAIL calc_pc: got %h want %h", o.pc_after, exp_pc + 8'd1); else n_pass++;
    exp_pc = exp_pc + 8'd1;
  endtask

  task automatic test_copy_in();
    obs_t o;
    run_instr(8'b10_110_001, 0, 3, 0, 1'b0, 8'h00, o);
    n_checks++; if (o.wr_sel !== 3'd1) $display("FAIL copy_in_wr_sel: got %0d want 1", o.wr_sel); else n_pass++;
    n_checks++; if (o.rd_sel !== 3'd6) $display("FAIL copy_in_rd_sel: got %0d want 6", o.rd_sel); else n_pass++;
    n_checks++; if (o.exec_cyc !== 4) $display("FAIL copy_in_exec_cycles: got %0d want 4", o.exec_cyc); else n_pass++;
    n_checks++; if (o.wr_n !== 1 || o.wr_at !== 3) $display("FAIL copy_in_wr_en: got n=%0d at=%0d want n=1 at=3", o.wr_n, o.wr_at); else n_pass++;
    n_checks++; if (o.in_rdy_n !== 1) $display("FAIL copy_in_in_ready: got %0d want 1", o.in_rdy_n); else n_pass++;
    n_checks++; if (o.sel_changed !== 1'b0) $display("FAIL copy_in_sel_held: got %b want 0", o.sel_changed); else n_pass++;
    n_checks++; if (o.pc_after !== exp_pc + 8'd1) $display("FAIL copy_in_pc: got %h want %h", o.pc_after, exp_pc + 8'd1); else n_pass++;
    exp_pc = exp_pc + 8'd1;
  endtask

  task automatic test_copy_out();
    obs_t o;
    run_instr(8'b10_010_110, 0, 0, 2, 1'b0, 8'h00, o);
    n_checks++; if (o.out_v_n !== 3) $display("FAIL copy_out_valid_cycles: got %0d want 3", o.out_v_n); else n_pass++;
    n_checks++; if (o.exec_cyc !== 3) $display("FAIL copy_out_retire_cycle: got %0d want 3", o.exec_cyc); else n_pass++;
    n_checks++; if (o.wr_n !== 0) $display("FAIL copy_out_no_wr_en: got %0d want 0", o.wr_n); else n_pass++;
    n_checks++; if (o.pc_after !== exp_pc + 8'd1) $display("FAIL copy_out_pc: got %h want %h", o.pc_after, exp_pc + 8'd1); else n_pass++;
    exp_pc = exp_pc + 8'd1;
  endtask

  task automatic test_cond();
    obs_t o;
    run_instr(8'b11_000_100, 0, 0, 0, 1'b1, 8'h40, o);
    n_checks++; if (o.pc_after !== 8'h40) $display("FAIL cond_taken_pc: got %h want 40", o.pc_after); else n_pass++;
    n_checks++; if (o.cond_sel !== 3'd4) $display("FAIL cond_sel: got %0d want 4", o.cond_sel); else n_pass++;
    run_instr(8'b11_000_100, 1, 0, 0, 1'b0, 8'h40, o);
    n_checks++; if (o.pc_after !== 8'h41) $display("FAIL cond_not_taken_pc: got %h want 41", o.pc_after); else n_pass++;
    run_instr(8'b11_000_100, 0, 0, 0, 1'b1, 8'hFF, o);
    run_instr(8'h05, 0, 0, 0, 1'b0, 8'h00, o);
    n_checks++; if (o.pc_after !== 8'h00) $display("FAIL pc_wrap: got %h want 00", o.pc_after); else n_pass++;
    exp_pc = 8'h00;
  endtask

  task automatic test_illegal();
    obs_t o;
    run_instr(8'b10_111_000, 0, 0, 0, 1'b0, 8'h00, o);
    n_checks++; if (bus.err_illegal !== 1'b1) $display("FAIL illegal_err_set: got %b want 1", bus.err_illegal); else n_pass++;
    n_checks++; if (o.exec_cyc !== 1 || o.retire_n !== 1) $display("FAIL illegal_retire: got cyc=%0d ret=%0d want 1/1", o.exec_cyc, o.retire_n); else n_pass++;
    n_checks++; if (o.wr_n + o.in_rdy_n + o.out_v_n !== 0) $display("FAIL illegal_no_strobes: got %0d want 0", o.wr_n + o.in_rdy_n + o.out_v_n); else n_pass++;
    exp_pc = exp_pc + 8'd1;
    run_instr(8'h07, 0, 0, 0, 1'b0, 8'h00, o);
    n_checks++; if (bus.err_illegal !== 1'b1) $display("FAIL illegal_err_sticky: got %b want 1", bus.err_illegal); else n_pass++;
    n_checks++; if (o.pc_after !== exp_pc + 8'd1) $display("FAIL illegal_pc: got %h want %h", o.pc_after, exp_pc + 8'd1); else n_pass++;
    exp_pc = exp_pc + 8'd1;
  endtask

  task automatic test_reset_mid_stall();
    bus.imem_valid = 1'b1;
    bus.instr      = 8'b10_110_001;
    @(posedge clk); #1;
    bus.imem_valid = 1'b0;
    bus.in_valid   = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL rst_stall_in_ready: got %b want 0", bus.in_ready); else n_pass++;
    n_checks++; if (bus.wr_en !== 1'b0 || bus.retire !== 1'b0) $display("FAIL rst_stall_strobes: got wr=%b ret=%b want 0/0", bus.wr_en, bus.retire); else n_pass++;
    @(posedge clk); #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.pc !== 8'h00) $display("FAIL rst_stall_pc: got %h want 00", bus.pc); else n_pass++;
    n_checks++; if (bus.imem_req !== 1'b1) $display("FAIL rst_stall_fetch: got %b want 1", bus.imem_req); else n_pass++;
    n_checks++; if (bus.err_illegal !== 1'b0) $display("FAIL rst_stall_err_clear: got %b want 0", bus.err_illegal); else n_pass++;
    @(posedge clk); #1;
    exp_pc  = 8'h00;
    exp_err = 1'b0;
  endtask

  task automatic test_random_program();
    obs_t       o, e;
    logic [7:0] ins, tgt;
    int         fw, idl, odl;
    bit         ct, is_copy, is_cc;
    for (int n = 0; n < 40; n++) begin
      ins = 8'($urandom_range(0, 255));
      tgt = 8'($urandom_range(0, 255));
      fw  = int'($urandom_range(0, 2));
      idl = int'($urandom_range(0, 3));
      odl = int'($urandom_range(0, 3));
      ct  = 1'($urandom_range(0, 1));
      e   = model(ins, fw, idl, odl, ct, tgt, exp_pc);
      run_instr(ins, fw, idl, odl, ct, tgt, o);
      is_copy = (ins[7:6] == 2'b10);
      is_cc   = (ins[7:6] == 2'b01 || ins[7:6] == 2'b11);
      if (is_copy && (ins[5:3] == 3'd7 || ins[2:0] == 3'd7)) exp_err = 1'b1;
      n_checks++; if (o.fetch_cyc !== e.fetch_cyc || o.fetch_strobe !== 1'b0) $display("FAIL rnd%0d_fetch ins=%h: got cyc=%0d strobe=%b want %0d/0", n, ins, o.fetch_cyc, o.fetch_strobe, e.fetch_cyc); else n_pass++;
      n_checks++; if (o.exec_cyc !== e.exec_cyc || o.retire_n !== 1) $display("FAIL rnd%0d_exec ins=%h: got cyc=%0d ret=%0d want %0d/1", n, ins, o.exec_cyc, o.retire_n, e.exec_cyc); else n_pass++;
      n_checks++; if (o.imm_n !== e.imm_n || o.alu_n !== e.alu_n) $display("FAIL rnd%0d_imm_alu ins=%h: got %0d/%0d want %0d/%0d", n, ins, o.imm_n, o.alu_n, e.imm_n, e.alu_n); else n_pass++;
      n_checks++; if (o.wr_n !== e.wr_n || o.wr_at !== e.wr_at) $display("FAIL rnd%0d_wr_en ins=%h: got n=%0d at=%0d want n=%0d at=%0d", n, ins, o.wr_n, o.wr_at, e.wr_n, e.wr_at); else n_pass++;
      n_checks++; if (o.in_rdy_n !== e.in_rdy_n || o.out_v_n !== e.out_v_n) $display("FAIL rnd%0d_io ins=%h: got rdy=%0d ov=%0d want %0d/%0d", n, ins, o.in_rdy_n, o.out_v_n, e.in_rdy_n, e.out_v_n); else n_pass++;
      n_checks++; if (o.pc_after !== e.pc_after) $display("FAIL rnd%0d_pc ins=%h: got %h want %h", n, ins, o.pc_after, e.pc_after); else n_pass++;
      n_checks++; if (bus.err_illegal !== exp_err) $display("FAIL rnd%0d_err_illegal ins=%h: got %b want %b", n, ins, bus.err_illegal, exp_err); else n_pass++;
      n_checks++; if (o.sel_changed !== 1'b0) $display("FAIL rnd%0d_sel_held ins=%h: got %b want 0", n, ins, o.sel_changed); else n_pass++;
      if (is_copy) begin
        n_checks++; if (o.rd_sel !== e.rd_sel || o.wr_sel !== e.wr_sel) $display("FAIL rnd%0d_copy_sel ins=%h: got %0d/%0d want %0d/%0d", n, ins, o.rd_sel, o.wr_sel, e.rd_sel, e.wr_sel); else n_pass++;
      end
      if (is_cc) begin
        n_checks++; if (o.cond_sel !== e.cond_sel) $display("FAIL rnd%0d_cond_sel ins=%h: got %0d want %0d", n, ins, o.cond_sel, e.cond_sel); else n_pass++;
      end
      exp_pc = e.pc_after;
    end
  endtask

`ifdef OVERTURE_SEQ_WATCHDOG_EN
  task automatic test_watchdog();
    obs_t o;
    int   ret_n;
    run_instr(8'b10_010_110, 0, 0, 99, 1'b0, 8'h00, o);
    n_checks++; if (o.exec_cyc !== int'(WDOG_MAX)) $display("FAIL wdog_exec_abandon: got %0d want %0d", o.exec_cyc, WDOG_MAX); else n_pass++;
    n_checks++; if (o.retire_n !== 1 || o.wr_n !== 0) $display("FAIL wdog_retire_nowrite: got ret=%0d wr=%0d want 1/0", o.retire_n, o.wr_n); else n_pass++;
    n_checks++; if (bus.err_timeout !== 1'b1) $display("FAIL wdog_err_timeout: got %b want 1", bus.err_timeout); else n_pass++;
    n_checks++; if (o.pc_after !== exp_pc + 8'd1) $display("FAIL wdog_exec_pc: got %h want %h", o.pc_after, exp_pc + 8'd1); else n_pass++;
    exp_pc = exp_pc + 8'd1;
    ret_n  = 0;
    bus.imem_valid = 1'b0;
    for (int k = 0; k < int'(WDOG_MAX); k++) begin
      @(negedge clk);
      if (bus.retire === 1'b1) ret_n++;
      @(posedge clk); #1;
    end
    n_checks++; if (bus.pc !== exp_pc + 8'd1) $display("FAIL wdog_fetch_pc: got %h want %h", bus.pc, exp_pc + 8'd1); else n_pass++;
    n_checks++; if (ret_n !== 0) $display("FAIL wdog_fetch_no_retire: got %0d want 0", ret_n); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.imem_req !== 1'b1) $display("FAIL wdog_fetch_stays: got %b want 1", bus.imem_req); else n_pass++;
    @(posedge clk); #1;
    exp_pc = exp_pc + 8'd1;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.imem_valid  = 1'b0;
    bus.instr       = 8'h00;
    bus.cond_true   = 1'b0;
    bus.jump_target = 8'h00;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    test_reset();
    test_imm();
    test_calc();
    test_copy_in();
    test_copy_out();
    test_cond();
    test_illegal();
    test_reset_mid_stall();
    test_random_program();
`ifdef OVERTURE_SEQ_WATCHDOG_EN
    test_watchdog();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
